// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM login controller around the combinational account authenticator
// Card lookup, PIN check against an internal table, per-account retry lock and PIN-entry timeout.
module atm_session_ctrl #(
   parameter int NUM_ACCOUNTS   = 10,
   parameter int MAX_TRIES      = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_valid_i,
   input  logic [3:0]  card_acc_num_i,
   input  logic        pin_valid_i,
   input  logic [15:0] pin_in_i,
   input  logic        card_eject_i,
   output logic [3:0]  auth_acc_num_o,
   input  logic [3:0]  auth_acc_index_i,
   input  logic        auth_found_i,
   output logic        session_active_o,
   output logic [3:0]  session_acc_index_o,
   output logic        login_ok_o,
   output logic        login_fail_o,
   output logic        card_retained_o,
   output logic [2:0]  error_code_o,
   output logic        busy_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
   localparam logic [3:0]    NUM_ACC_W   = 4'(NUM_ACCOUNTS);
   localparam logic [2:0]    MAX_TRIES_W = 3'(MAX_TRIES);

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_NOTFOUND = 3'd1;
   localparam logic [2:0] ERR_WRONGPIN = 3'd2;
   localparam logic [2:0] ERR_LOCKED   = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WAIT_PIN,
      S_CHECK,
      S_ACTIVE
   } state_e;

   state_e                      state_q, state_d;
   logic [3:0]                  acc_num_q, acc_num_d;
   logic [3:0]                  idx_q, idx_d;
   logic [15:0]                 pin_q, pin_d;
   logic [TW-1:0]               timer_q, timer_d;
   logic [2:0]                  err_q, err_d;
   logic                        ok_q, ok_d;
   logic                        fail_q, fail_d;
   logic                        ret_q, ret_d;
   logic [NUM_ACCOUNTS-1:0]     lock_q, lock_d;
   logic [NUM_ACCOUNTS-1:0][1:0] tries_q, tries_d;
   logic [2:0]                  tries_inc;

   // PINs are stored as the plain binary of the decimal value.
   function automatic logic [15:0] pin_table(input logic [3:0] i);
      case (i)
         4'd0:    pin_table = 16'd1234;
         4'd1:    pin_table = 16'd2345;
         4'd2:    pin_table = 16'd3456;
         4'd3:    pin_table = 16'd4567;
         4'd4:    pin_table = 16'd5678;
         4'd5:    pin_table = 16'd6789;
         4'd6:    pin_table = 16'd7890;
         4'd7:    pin_table = 16'd8901;
         4'd8:    pin_table = 16'd9012;
         4'd9:    pin_table = 16'd7123;
         default: pin_table = 16'd0;
      endcase
   endfunction

   assign tries_inc = {1'b0, tries_q[idx_q]} + 3'd1;

   always_comb begin
      state_d   = state_q;
      acc_num_d = acc_num_q;
      idx_d     = idx_q;
      pin_d     = pin_q;
      timer_d   = timer_q;
      err_d     = err_q;
      ok_d      = 1'b0;
      fail_d    = 1'b0;
      ret_d     = 1'b0;
      lock_d    = lock_q;
      tries_d   = tries_q;
      case (state_q)
         S_IDLE: begin
            if (card_valid_i) begin
               acc_num_d = card_acc_num_i;
               err_d     = ERR_NONE;
               state_d   = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            // An out-of-range index from the authenticator is treated as not found.
            if (!auth_found_i || (auth_acc_index_i >= NUM_ACC_W)) begin
               err_d   = ERR_NOTFOUND;
               fail_d  = 1'b1;
               state_d = S_IDLE;
            end else if (lock_q[auth_acc_index_i]) begin
               err_d   = ERR_LOCKED;
               ret_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               idx_d   = auth_acc_index_i;
               timer_d = '0;
               state_d = S_WAIT_PIN;
            end
         end
         S_WAIT_PIN: begin
            if (card_eject_i) begin
               err_d   = ERR_NONE;
               state_d = S_IDLE;
            end else if (pin_valid_i) begin
               pin_d   = pin_in_i;
               state_d = S_CHECK;
            end else if (timer_q == TIMER_LAST) begin
               err_d   = ERR_TIMEOUT;
               fail_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         S_CHECK: begin
            if (pin_q == pin_table(idx_q)) begin
               tries_d[idx_q] = 2'd0;
               ok_d           = 1'b1;
               state_d        = S_ACTIVE;
            end else if (tries_inc == MAX_TRIES_W) begin
               lock_d[idx_q]  = 1'b1;
               tries_d[idx_q] = 2'd0;
               err_d          = ERR_LOCKED;
               fail_d         = 1'b1;
               ret_d          = 1'b1;
               state_d        = S_IDLE;
            end else begin
               tries_d[idx_q] = tries_inc[1:0];
               err_d          = ERR_WRONGPIN;
               fail_d         = 1'b1;
               timer_d        = '0;
               state_d        = S_WAIT_PIN;
            end
         end
         S_ACTIVE: begin
            if (card_eject_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_num_q <= '0;
         idx_q     <= '0;
         pin_q     <= '0;
         timer_q   <= '0;
         err_q     <= ERR_NONE;
         ok_q      <= 1'b0;
         fail_q    <= 1'b0;
         ret_q     <= 1'b0;
         lock_q    <= '0;
         tries_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_num_q <= acc_num_d;
         idx_q     <= idx_d;
         pin_q     <= pin_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         ok_q      <= ok_d;
         fail_q    <= fail_d;
         ret_q     <= ret_d;
         lock_q    <= lock_d;
         tries_q   <= tries_d;
      end
   end

   assign auth_acc_num_o      = acc_num_q;
   assign session_active_o    = (state_q == S_ACTIVE);
   assign session_acc_index_o = (state_q == S_ACTIVE) ? idx_q : 4'd0;
   assign login_ok_o          = ok_q;
   assign login_fail_o        = fail_q;
   assign card_retained_o     = ret_q;
   assign error_code_o        = err_q;
   assign busy_o              = (state_q != S_IDLE);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - scoreboard bench for atm_session_ctrl with a behavioural login model
module tb_atm_session_ctrl;

   localparam int TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        card_valid = 1'b0;
   logic [3:0]  card_acc_num = 4'd0;
   logic        pin_valid = 1'b0;
   logic [15:0] pin_in = 16'd0;
   logic        card_eject = 1'b0;
   logic [3:0]  auth_acc_num;
   logic [3:0]  auth_acc_index;
   logic        auth_found;
   logic        session_active;
   logic [3:0]  session_acc_index;
   logic        login_ok;
   logic        login_fail;
   logic        card_retained;
   logic [2:0]  error_code;
   logic        busy;

   atm_session_ctrl #(.NUM_ACCOUNTS(10), .MAX_TRIES(3), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .card_valid_i        (card_valid),
      .card_acc_num_i      (card_acc_num),
      .pin_valid_i         (pin_valid),
      .pin_in_i            (pin_in),
      .card_eject_i        (card_eject),
      .auth_acc_num_o      (auth_acc_num),
      .auth_acc_index_i    (auth_acc_index),
      .auth_found_i        (auth_found),
      .session_active_o    (session_active),
      .session_acc_index_o (session_acc_index),
      .login_ok_o          (login_ok),
      .login_fail_o        (login_fail),
      .card_retained_o     (card_retained),
      .error_code_o        (error_code),
      .busy_o              (busy)
   );

   always #5 clk = ~clk;

   // Authenticator stand-in: 0..9 found, 10..13 missing, 14..15 claim found with a bogus index.
   always_comb begin
      auth_found     = (auth_acc_num < 4'd10) || (auth_acc_num >= 4'd14);
      auth_acc_index = auth_acc_num;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic       ok;
      logic       fail;
      logic       ret;
      logic [2:0] err;
      logic       act;
      logic [3:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int passes = 0;

   int pin_tab[10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
   int locked[10];
   int tries[10];
   int m_err = 0;
   int m_idx = 0;
   bit m_wait = 0;
   bit m_active = 0;
   int wait_start = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            checks++;
            $display("FAIL missed_pulse expected at cycle %0d, still pending at cycle %0d", e.at, cyc);
         end
         if (login_ok || login_fail || card_retained) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL spurious_pulse cycle %0d ok=%b fail=%b ret=%b err=%0d",
                        cyc, login_ok, login_fail, card_retained, error_code);
            end else begin
               e = exp_q.pop_front();
               if (e.at == cyc && login_ok == e.ok && login_fail == e.fail &&
                   card_retained == e.ret && error_code == e.err && session_active == e.act &&
                   (!e.act || session_acc_index == e.idx))
                  passes++;
               else
                  $display("FAIL result got cyc=%0d ok=%b fail=%b ret=%b err=%0d act=%b idx=%0d required cyc=%0d ok=%b fail=%b ret=%b err=%0d act=%b idx=%0d",
                           cyc, login_ok, login_fail, card_retained, error_code, session_active,
                           session_acc_index, e.at, e.ok, e.fail, e.ret, e.err, e.act, e.idx);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s got %0d required %0d", name, got, want);
   endtask

   task automatic expect_pulse(input int at, input logic ok, input logic fail, input logic ret,
                               input int err, input logic act, input int idx);
      exp_t e;
      e.at = at; e.ok = ok; e.fail = fail; e.ret = ret;
      e.err = 3'(err); e.act = act; e.idx = 4'(idx);
      exp_q.push_back(e);
   endtask

   task automatic do_card(input int n);
      int c0;
      c0 = cyc;
      m_err = 0;
      m_wait = 0;
      if (n >= 10) begin
         m_err = 1;
         expect_pulse(c0 + 2, 0, 1, 0, 1, 0, 0);
      end else if (locked[n] != 0) begin
         m_err = 3;
         expect_pulse(c0 + 2, 0, 0, 1, 3, 0, 0);
      end else begin
         m_idx = n;
         m_wait = 1;
      end
      card_acc_num = 4'(n);
      card_valid = 1'b1;
      @(negedge clk);
      card_valid = 1'b0;
      @(negedge clk);
      if (m_wait) wait_start = cyc;
      chk("card_busy", busy, m_wait);
      chk("card_error_code", error_code, m_err);
      chk("auth_acc_num", auth_acc_num, n);
   endtask

   task automatic do_pin(input int p, input bit dbl, input int p2);
      int c0;
      c0 = cyc;
      if (p == pin_tab[m_idx]) begin
         tries[m_idx] = 0;
         m_wait = 0;
         m_active = 1;
         expect_pulse(c0 + 2, 1, 0, 0, m_err, 1, m_idx);
      end else if (tries[m_idx] + 1 == 3) begin
         locked[m_idx] = 1;
         tries[m_idx] = 0;
         m_err = 3;
         m_wait = 0;
         expect_pulse(c0 + 2, 0, 1, 1, 3, 0, 0);
      end else begin
         tries[m_idx]++;
         m_err = 2;
         expect_pulse(c0 + 2, 0, 1, 0, 2, 0, 0);
      end
      pin_in = 16'(p);
      pin_valid = 1'b1;
      @(negedge clk);
      if (dbl) pin_in = 16'(p2);
      else pin_valid = 1'b0;
      @(negedge clk);
      pin_valid = 1'b0;
      if (m_wait) wait_start = cyc;
      chk("pin_busy", busy, (m_wait || m_active) ? 1 : 0);
      chk("pin_session_active", session_active, m_active);
      chk("pin_error_code", error_code, m_err);
   endtask

   task automatic do_eject();
      card_eject = 1'b1;
      @(negedge clk);
      card_eject = 1'b0;
      if (m_wait) m_err = 0;
      m_wait = 0;
      m_active = 0;
      chk("eject_busy", busy, 0);
      chk("eject_session_active", session_active, 0);
      chk("eject_error_code", error_code, m_err);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_outputs", int'({auth_acc_num, session_active, session_acc_index, login_ok,
                                 login_fail, card_retained, error_code, busy}), 0);
      for (int i = 0; i < 10; i++) begin
         locked[i] = 0;
         tries[i] = 0;
      end
      m_err = 0; m_wait = 0; m_active = 0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      do_reset();

      do_card(3); do_pin(4567, 0, 0);
      chk("session_acc_index", session_acc_index, 3);
      do_eject();

      do_card(12);
      do_card(15);

      do_card(5); do_pin(1111, 0, 0); do_pin(2222, 0, 0); do_pin(3333, 0, 0);
      do_card(5);

      do_card(0); do_pin(9999, 0, 0); do_pin(1234, 0, 0); do_eject();
      do_card(0); do_pin(1111, 0, 0); do_eject();
      do_card(0); do_pin(2222, 0, 0); do_eject();
      do_card(0); do_eject();

      do_card(7);
      expect_pulse(wait_start + TIMEOUT, 0, 1, 0, 4, 0, 0);
      wait_until(wait_start + TIMEOUT);
      m_err = 4; m_wait = 0;
      chk("timeout_busy", busy, 0);
      chk("timeout_error_code", error_code, 4);

      do_card(7);
      wait_until(wait_start + TIMEOUT - 1);
      card_eject = 1'b1; pin_valid = 1'b1; pin_in = 16'd8901;
      @(negedge clk);
      card_eject = 1'b0; pin_valid = 1'b0;
      m_err = 0; m_wait = 0;
      chk("expiry_eject_busy", busy, 0);
      chk("expiry_eject_error_code", error_code, 0);

      do_card(8);
      wait_until(wait_start + TIMEOUT - 1);
      do_pin(9012, 0, 0);
      do_eject();

      do_card(2); do_pin(1000, 1, 3456);
      chk("check_drop_session_active", session_active, 0);
      do_eject();

      do_card(3); do_pin(4567, 0, 0);
      @(negedge clk);
      do_reset();

      do_card(5); do_pin(1, 0, 0); do_pin(2, 0, 0); do_pin(3, 0, 0);
      do_card(5);
      do_reset();
      do_card(5); do_pin(6789, 0, 0);
      chk("relogin_index", session_acc_index, 5);
      do_eject();

      for (int it = 0; it < 40; it++) begin
         int n;
         int att;
         int p;
         n = $urandom_range(0, 15);
         do_card(n);
         if (m_wait) begin
            att = $urandom_range(1, 4);
            for (int a = 0; a < att && m_wait; a++) begin
               p = ($urandom_range(0, 1) == 1) ? pin_tab[m_idx] : $urandom_range(0, 9999);
               do_pin(p, 0, 0);
            end
         end
         if (m_wait || m_active) do_eject();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
